// File: rtl/stopwatch_key_ctrl.sv
// stopwatch_key_ctrl: edge-detects the debounced start/clear keys, classifies clear as short or long,
// and runs the IDLE/RUNNING/PAUSED stopwatch FSM that drives the counter and display controls.
module stopwatch_key_ctrl #(
    parameter int LONG_PRESS_CYCLES = 100_000_000,
    parameter int KEY_ACTIVE_LOW    = 1
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_i,
    input  logic       key_clear_i,
    output logic       count_en_o,
    output logic       count_clr_o,
    output logic       disp_freeze_o,
    output logic [1:0] run_state_o
);
    localparam int CW = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic PRESSED = (KEY_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [CW-1:0] LONG_AT = CW'(LONG_PRESS_CYCLES - 1);
    typedef enum logic [1:0] {IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10} state_t;
    state_t state_q;
    logic start_q, start_prev_q, clear_q, clear_prev_q;
    logic [CW-1:0] hold_q, hold_d;
    logic long_done_q, long_done_d, armed_q, armed_d;
    logic count_en_q, count_clr_q, disp_freeze_q;
    logic start_press, clear_press, clear_held, clear_release, long_ev, short_ev;
    // armed_q marks a clear press seen since reset, so a key held through reset never fires an event
    always_comb begin
        start_press   = start_q == PRESSED && start_prev_q != PRESSED;
        clear_held    = clear_q == PRESSED;
        clear_press   = clear_held && clear_prev_q != PRESSED;
        clear_release = !clear_held && clear_prev_q == PRESSED;
        long_ev       = armed_q && clear_held && !long_done_q && hold_q == LONG_AT;
        short_ev      = armed_q && clear_release && !long_done_q;
        hold_d        = clear_press ? '0 : (clear_held && hold_q != '1) ? hold_q + 1'b1 : hold_q;
        long_done_d   = clear_release ? 1'b0 : (long_done_q | long_ev);
        armed_d       = clear_press | (armed_q & !clear_release);
    end
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            start_q      <= PRESSED;
            start_prev_q <= PRESSED;
            clear_q      <= PRESSED;
            clear_prev_q <= PRESSED;
            hold_q       <= '0;
            long_done_q  <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            start_q      <= key_start_i;
            start_prev_q <= start_q;
            clear_q      <= key_clear_i;
            clear_prev_q <= clear_q;
            hold_q       <= hold_d;
            long_done_q  <= long_done_d;
            armed_q      <= armed_d;
        end
    end
    // clear events take priority over a start press in the same cycle
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            state_q       <= IDLE;
            count_en_q    <= 1'b0;
            count_clr_q   <= 1'b0;
            disp_freeze_q <= 1'b0;
        end else begin
            count_clr_q <= 1'b0;
            if (long_ev || (short_ev && state_q != RUNNING)) begin
                state_q       <= IDLE;
                count_en_q    <= 1'b0;
                count_clr_q   <= 1'b1;
                disp_freeze_q <= 1'b0;
            end else if (short_ev) begin
                disp_freeze_q <= !disp_freeze_q;
            end else if (start_press) begin
                state_q    <= (state_q == RUNNING) ? PAUSED : RUNNING;
                count_en_q <= state_q != RUNNING;
            end
        end
    end
    assign count_en_o    = count_en_q;
    assign count_clr_o   = count_clr_q;
    assign disp_freeze_o = disp_freeze_q;
    assign run_state_o   = state_q;
endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// tb_stopwatch_key_ctrl: directed vector table plus a hand-written async reset sequence
// for stopwatch_key_ctrl with LONG_PRESS_CYCLES=16 and active-low keys.
module tb_stopwatch_key_ctrl;
    logic clk = 1'b0, key_reset = 1'b0, key_start = 1'b0, key_clear = 1'b0;
    logic count_en, count_clr, disp_freeze;
    logic [1:0] run_state;
    int checks = 0, errors = 0, pulses = 0, consec = 0;
    logic last_clr = 1'b0;
    typedef struct {
        logic s; logic c; int n; logic [1:0] st; logic en; logic fr; int p;
    } vec_t;
    vec_t v[43];

    stopwatch_key_ctrl #(.LONG_PRESS_CYCLES(16), .KEY_ACTIVE_LOW(1)) dut (
        .clk(clk), .key_reset(key_reset), .key_start_i(key_start), .key_clear_i(key_clear),
        .count_en_o(count_en), .count_clr_o(count_clr), .disp_freeze_o(disp_freeze),
        .run_state_o(run_state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (count_clr) begin
                pulses++;
                if (last_clr) consec++;
            end
            last_clr = count_clr;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        key_start = v[i].s;
        key_clear = v[i].c;
        pulses = 0;
        step(v[i].n);
        chk($sformatf("v%0d run_state", i), 32'(run_state), 32'(v[i].st));
        chk($sformatf("v%0d count_en", i), 32'(count_en), 32'(v[i].en));
        chk($sformatf("v%0d disp_freeze", i), 32'(disp_freeze), 32'(v[i].fr));
        chk($sformatf("v%0d clr_pulses", i), 32'(pulses), 32'(v[i].p));
    endtask

    initial begin
        // keys: 1 = released, 0 = pressed; fields s, c, cycles, state, en, freeze, pulses
        v[0]  = '{1'b0, 1'b0, 50, 2'd0, 1'b0, 1'b0, 0};
        v[1]  = '{1'b1, 1'b1, 5,  2'd0, 1'b0, 1'b0, 0};
        v[2]  = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b0, 0};
        v[3]  = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b0, 0};
        v[4]  = '{1'b0, 1'b1, 2,  2'd2, 1'b0, 1'b0, 0};
        v[5]  = '{1'b1, 1'b1, 3,  2'd2, 1'b0, 1'b0, 0};
        v[6]  = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b0, 0};
        v[7]  = '{1'b0, 1'b1, 10, 2'd1, 1'b1, 1'b0, 0};
        v[8]  = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b0, 0};
        v[9]  = '{1'b1, 1'b0, 5,  2'd1, 1'b1, 1'b0, 0};
        v[10] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b1, 0};
        v[11] = '{1'b1, 1'b0, 5,  2'd1, 1'b1, 1'b1, 0};
        v[12] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b0, 0};
        v[13] = '{1'b0, 1'b1, 2,  2'd2, 1'b0, 1'b0, 0};
        v[14] = '{1'b1, 1'b1, 3,  2'd2, 1'b0, 1'b0, 0};
        v[15] = '{1'b1, 1'b0, 5,  2'd2, 1'b0, 1'b0, 0};
        v[16] = '{1'b1, 1'b1, 3,  2'd0, 1'b0, 1'b0, 1};
        v[17] = '{1'b1, 1'b0, 5,  2'd0, 1'b0, 1'b0, 0};
        v[18] = '{1'b1, 1'b1, 3,  2'd0, 1'b0, 1'b0, 1};
        v[19] = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b0, 0};
        v[20] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b0, 0};
        v[21] = '{1'b1, 1'b0, 5,  2'd1, 1'b1, 1'b0, 0};
        v[22] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b1, 0};
        v[23] = '{1'b0, 1'b1, 2,  2'd2, 1'b0, 1'b1, 0};
        v[24] = '{1'b1, 1'b1, 3,  2'd2, 1'b0, 1'b1, 0};
        v[25] = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b1, 0};
        v[26] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b1, 0};
        v[27] = '{1'b1, 1'b0, 16, 2'd1, 1'b1, 1'b1, 0};
        v[28] = '{1'b1, 1'b0, 1,  2'd1, 1'b1, 1'b1, 0};
        v[29] = '{1'b1, 1'b0, 1,  2'd0, 1'b0, 1'b0, 1};
        v[30] = '{1'b1, 1'b0, 22, 2'd0, 1'b0, 1'b0, 0};
        v[31] = '{1'b1, 1'b1, 3,  2'd0, 1'b0, 1'b0, 0};
        v[32] = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b0, 0};
        v[33] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b0, 0};
        v[34] = '{1'b1, 1'b0, 5,  2'd1, 1'b1, 1'b0, 0};
        v[35] = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b1, 0};
        v[36] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b1, 0};
        v[37] = '{1'b0, 1'b0, 30, 2'd0, 1'b0, 1'b0, 0};
        v[38] = '{1'b1, 1'b1, 3,  2'd0, 1'b0, 1'b0, 0};
        v[39] = '{1'b0, 1'b1, 2,  2'd1, 1'b1, 1'b0, 0};
        v[40] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b0, 0};
        v[41] = '{1'b1, 1'b0, 5,  2'd1, 1'b1, 1'b0, 0};
        v[42] = '{1'b1, 1'b1, 3,  2'd1, 1'b1, 1'b1, 0};

        step(3);
        chk("reset run_state", 32'(run_state), 32'd0);
        chk("reset count_en", 32'(count_en), 32'd0);
        chk("reset count_clr", 32'(count_clr), 32'd0);
        chk("reset disp_freeze", 32'(disp_freeze), 32'd0);
        @(negedge clk) key_reset = 1'b1;
        for (int i = 0; i < 37; i++) run_vec(i);

        // asynchronous reset in the middle of a clear hold while RUNNING with freeze set
        key_clear = 1'b0;
        pulses = 0;
        step(8);
        chk("pre-reset run_state", 32'(run_state), 32'd1);
        #2 key_reset = 1'b0;
        #1;
        chk("async reset run_state", 32'(run_state), 32'd0);
        chk("async reset count_en", 32'(count_en), 32'd0);
        chk("async reset count_clr", 32'(count_clr), 32'd0);
        chk("async reset disp_freeze", 32'(disp_freeze), 32'd0);
        key_start = 1'b0;
        step(2);
        chk("in-reset run_state", 32'(run_state), 32'd0);
        @(negedge clk) key_reset = 1'b1;
        for (int i = 37; i < 43; i++) run_vec(i);

        chk("back-to-back count_clr", 32'(consec), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
